// File: rtl/parallel_register.sv
`timescale 1ns/1ps
// parallel_register: n-bit load-enable register with asynchronous active-low clear.
//
// Built from n identical bit cells. Each cell is one D flip-flop with an
// async clear, fed by a 2:1 recirculating mux (en ? d : q). The bits are fully
// independent of each other.
//
// Ports (positional order d, q, en, rst, clk):
//   d   [n-1:0]  in   parallel data input
//   q   [n-1:0]  out  parallel data output, straight from the flops
//   en           in   load enable, active high
//   rst          in   asynchronous clear, active low (q -> 0)
//   clk          in   rising-edge clock

// One bit of storage: recirculating mux in front of an async-clear DFF.
module parallel_register_cell (
  input  logic d,
  output logic q,
  input  logic en,
  input  logic rst,
  input  logic clk
);

  logic d_mux;

  // Hold path feeds q back, so en=0 keeps the stored bit across edges.
  assign d_mux = en ? d : q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= d_mux;
  end

endmodule

module parallel_register #(
  parameter int n = 32
) (
  input  logic [n-1:0] d,
  output logic [n-1:0] q,
  input  logic         en,
  input  logic         rst,
  input  logic         clk
);

  // One cell per bit; q[i] depends only on d[i], en, rst and clk.
  for (genvar i = 0; i < n; i++) begin : g_bit
    parallel_register_cell u_cell (
      .d   (d[i]),
      .q   (q[i]),
      .en  (en),
      .rst (rst),
      .clk (clk)
    );
  end

endmodule

// File: tb/tb_parallel_register.sv
`timescale 1ns/1ps
module tb_parallel_register;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] d32, q32;
  logic [7:0]  d8, q8;
  logic [0:0]  d1, q1;

  // Reference state: what each register should hold right now.
  logic [31:0] exp32;
  logic [7:0]  exp8;
  logic [0:0]  exp1;

  int n_tests = 0;
  int n_fail  = 0;

  parallel_register #(.n(32)) u_dut32 (.d(d32), .q(q32), .en(en), .rst(rst), .clk(clk));
  parallel_register #(.n(8))  u_dut8  (.d(d8),  .q(q8),  .en(en), .rst(rst), .clk(clk));
  parallel_register #(.n(1))  u_dut1  (.d(d1),  .q(q1),  .en(en), .rst(rst), .clk(clk));

  initial clk = 1'b0;
  always #1 clk = ~clk;  // 2 ns period

  // Reference model behaviour: asserting reset empties every register at once.
  task automatic assert_reset();
    rst = 1'b0;
    exp32 = '0; exp8 = '0; exp1 = '0;
  endtask

  // Drive inputs at a falling edge, advance through one rising edge and stop on
  // the next falling edge. Model: a register takes d on an enabled edge while
  // out of reset, otherwise it keeps what it had.
  task automatic tick(input logic en_v, input logic [31:0] dv, input logic [7:0] dv8,
                      input logic dv1);
    en = en_v; d32 = dv; d8 = dv8; d1 = dv1;
    if (rst && en_v) begin
      exp32 = dv; exp8 = dv8; exp1 = dv1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    en = 1'b0; d32 = 32'hFF0000FF; d8 = 8'hA5; d1 = 1'b1;
    assert_reset();
    #0.3;
    n_tests++;
    if ({q32, q8, q1} !== {exp32, exp8, exp1}) begin
      n_fail++;
      $display("FAIL reset_async got %h/%h/%h expected %h/%h/%h", q32, q8, q1, exp32, exp8, exp1);
    end
    @(negedge clk);
    tick(1'b0, 32'hFF0000FF, 8'hA5, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'hFF0000FF, 8'hA5, 1'b1);
      n_tests++;
      if ({q32, q8, q1} !== {41'd0}) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d got %h/%h/%h expected 0", i, q32, q8, q1);
      end
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 32'hFF0000FF, 8'hA5, 1'b1);
      n_tests++;
      if ({q32, q8, q1} !== {32'hFF0000FF, 8'hA5, 1'b1}) begin
        n_fail++;
        $display("FAIL load cyc%0d got %h/%h/%h expected ff0000ff/a5/1", i, q32, q8, q1);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h12345678, 8'h3C, 1'b0);
      n_tests++;
      if ({q32, q8, q1} !== {32'hFF0000FF, 8'hA5, 1'b1}) begin
        n_fail++;
        $display("FAIL hold cyc%0d got %h/%h/%h expected ff0000ff/a5/1", i, q32, q8, q1);
      end
    end
  endtask

  // Wiggle d and en between edges; q must not move until a rising edge.
  task automatic test_between_edges();
    en = 1'b1; d32 = 32'hDEADBEEF; d8 = 8'h5A; d1 = 1'b0;
    #0.4;
    en = 1'b0;
    #0.3;
    n_tests++;
    if ({q32, q8, q1} !== {exp32, exp8, exp1}) begin
      n_fail++;
      $display("FAIL between_edges got %h/%h/%h expected %h/%h/%h", q32, q8, q1, exp32, exp8, exp1);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    en = 1'b0;
    assert_reset();
    #0.2;  // next rising edge is still 0.8 ns away
    n_tests++;
    if ({q32, q8, q1} !== {41'd0}) begin
      n_fail++;
      $display("FAIL async_reset_immediate got %h/%h/%h expected 0", q32, q8, q1);
    end
    #1.8;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'hFF0000FF, 8'hA5, 1'b1);
      n_tests++;
      if ({q32, q8, q1} !== {41'd0}) begin
        n_fail++;
        $display("FAIL async_reset_release cyc%0d got %h/%h/%h expected 0", i, q32, q8, q1);
      end
    end
  endtask

  task automatic test_reset_priority();
    assert_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 32'hFF0000FF, 8'hA5, 1'b1);
      n_tests++;
      if ({q32, q8, q1} !== {41'd0}) begin
        n_fail++;
        $display("FAIL reset_priority cyc%0d got %h/%h/%h expected 0", i, q32, q8, q1);
      end
    end
    rst = 1'b1;
    tick(1'b1, 32'hFF0000FF, 8'hA5, 1'b1);
    n_tests++;
    if ({q32, q8, q1} !== {32'hFF0000FF, 8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_priority_first_load got %h/%h/%h expected ff0000ff/a5/1", q32, q8, q1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        assert_reset();
        #0.3;
        n_tests++;
        if ({q32, q8, q1} !== {41'd0}) begin
          n_fail++;
          $display("FAIL random_reset it%0d got %h/%h/%h expected 0", i, q32, q8, q1);
        end
        #0.3;
        rst = 1'b1;
        #0.1;
      end
      tick(1'($urandom_range(0, 1)), $urandom, 8'($urandom), 1'($urandom));
      n_tests++;
      if ({q32, q8, q1} !== {exp32, exp8, exp1}) begin
        n_fail++;
        $display("FAIL random it%0d got %h/%h/%h expected %h/%h/%h", i, q32, q8, q1, exp32, exp8, exp1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d32 = '0; d8 = '0; d1 = '0;
    exp32 = '0; exp8 = '0; exp1 = '0;
    @(negedge clk);
    test_reset();
    test_load();
    test_hold();
    test_between_edges();
    test_async_reset();
    test_reset_priority();
    test_between_edges();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
